// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART master endpoint:
//   - uart_state_e : state encoding used by both the TX and RX FSMs
//   - CLKS_PER_BIT_DEF / DATA_BITS_DEF : default frame timing and width
//   - parity_even  : even-parity bit over up to 32 data bits
// Optional build macro (affects users of this package): UART_PARITY_EN
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Even parity: the bit that makes the total count of ones even.
  // Callers zero-extend their data word to 32 bits, which leaves the XOR unchanged.
  function automatic logic parity_even(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// Receive half of the UART master: 2-flop synchronizer on the raw rx pin
// followed by a mid-bit sampling FSM (IDLE, START, DATA, [PARITY], STOP).
// Optional build macro: UART_PARITY_EN (adds an even-parity bit check).
// Ports:
//   clk            : system clock, rising edge
//   rst_n          : asynchronous active-low reset
//   i_rx           : serial input, asynchronous to clk
//   o_rx_data      : last correctly received byte
//   o_rx_valid     : 1-cycle pulse when o_rx_data is updated
//   o_rx_frame_err : 1-cycle pulse on bad stop bit (or bad parity)
// -----------------------------------------------------------------------------
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_rx_prev;
  uart_state_e          r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 w_sample;
  logic                 w_fall;
  logic                 w_par_ok;

`ifdef UART_PARITY_EN
  logic                 r_par_err;
  assign w_par_ok = ~r_par_err;
`else
  assign w_par_ok = 1'b1;
`endif

  // The counter is a down-counter; a sample point is reached when it hits 1.
  assign w_sample = (r_cnt == CNT_W'(1));
  // Start detection needs a real 1->0 edge, so a line stuck low after a
  // framing error is ignored until it has gone back high.
  assign w_fall   = r_rx_prev & ~r_sync2;

  // Synchronizer for the asynchronous rx pin plus one-cycle history for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= i_rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // RX FSM: half-bit offset from the start edge, then one sample per bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_bit       <= {BIT_W{1'b0}};
      r_shift     <= {DATA_BITS{1'b0}};
      r_rx_data   <= {DATA_BITS{1'b0}};
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      r_par_err   <= 1'b0;
`endif
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_bit <= {BIT_W{1'b0}};
          if (w_fall) begin
            r_state <= START;
            r_cnt   <= CNT_W'(CLKS_PER_BIT / 2);
`ifdef UART_PARITY_EN
            r_par_err <= 1'b0;
`endif
          end else begin
            r_cnt <= {CNT_W{1'b0}};
          end
        end
        START: begin
          if (w_sample) begin
            if (r_sync2) begin
              // Line back high at mid start bit: glitch, drop it silently.
              r_state <= IDLE;
              r_cnt   <= {CNT_W{1'b0}};
            end else begin
              r_state <= DATA;
              r_cnt   <= CNT_W'(CLKS_PER_BIT);
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DATA: begin
          if (w_sample) begin
            r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
            r_cnt   <= CNT_W'(CLKS_PER_BIT);
            if (r_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bit <= r_bit + BIT_W'(1);
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (w_sample) begin
            r_par_err <= r_sync2 ^ parity_even(32'(r_shift));
            r_state   <= STOP;
            r_cnt     <= CNT_W'(CLKS_PER_BIT);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (w_sample) begin
            if (r_sync2 && w_par_ok) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign o_rx_data      = r_rx_data;
  assign o_rx_valid     = r_rx_valid;
  assign o_rx_frame_err = r_frame_err;

endmodule

// File: rtl/uart_master.sv
// -----------------------------------------------------------------------------
// uart_master
// Full-duplex UART master endpoint: valid/ready byte stream <-> 8N1 serial.
// TX FSM lives here; the receive path is uart_rx_core.
// Optional build macro: UART_PARITY_EN (even parity bit after the data bits).
// Ports:
//   clk, rst_n     : clock (rising edge) and asynchronous active-low reset
//   i_tx_data      : byte to transmit, latched on i_tx_valid && o_tx_ready
//   i_tx_valid     : level valid; held high it sends consecutive bytes
//   o_tx_ready     : transmitter can accept a byte this cycle
//   o_rx_data      : last received byte
//   o_rx_valid     : 1-cycle pulse, o_rx_data updated
//   o_rx_frame_err : 1-cycle pulse, bad stop bit (or parity)
//   o_tx           : serial out, idle high
//   i_rx           : serial in, asynchronous to clk
// -----------------------------------------------------------------------------
module uart_master
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_rx_frame_err,
  output logic                 o_tx,
  input  logic                 i_rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  uart_state_e          r_tx_state;
  logic [CNT_W-1:0]     r_tx_cnt;
  logic [BIT_W-1:0]     r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx;
  logic                 r_tx_ready;
  logic                 w_tx_bit_end;
  logic                 w_tx_accept;
`ifdef UART_PARITY_EN
  logic                 r_tx_par;
`endif

  assign w_tx_bit_end = (r_tx_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_tx_accept  = i_tx_valid & r_tx_ready;

  // TX FSM. tx_ready is raised during the last stop-bit cycle so that a held
  // tx_valid starts the next frame on the very next edge with no idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= IDLE;
      r_tx_cnt   <= {CNT_W{1'b0}};
      r_tx_bit   <= {BIT_W{1'b0}};
      r_tx_shift <= {DATA_BITS{1'b0}};
      r_tx       <= 1'b1;
      r_tx_ready <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      case (r_tx_state)
        IDLE: begin
          r_tx_cnt <= {CNT_W{1'b0}};
          r_tx_bit <= {BIT_W{1'b0}};
          if (w_tx_accept) begin
            r_tx_shift <= i_tx_data;
`ifdef UART_PARITY_EN
            r_tx_par   <= parity_even(32'(i_tx_data));
`endif
            r_tx       <= 1'b0;
            r_tx_ready <= 1'b0;
            r_tx_state <= START;
          end else begin
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
          end
        end
        START: begin
          if (w_tx_bit_end) begin
            r_tx_state <= DATA;
            r_tx_cnt   <= {CNT_W{1'b0}};
            r_tx_bit   <= {BIT_W{1'b0}};
            r_tx       <= r_tx_shift[0];
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= {CNT_W{1'b0}};
            if (r_tx_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              r_tx_state <= PARITY;
              r_tx       <= r_tx_par;
`else
              r_tx_state <= STOP;
              r_tx       <= 1'b1;
`endif
            end else begin
              r_tx_bit   <= r_tx_bit + BIT_W'(1);
              r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
              r_tx       <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (w_tx_bit_end) begin
            r_tx_state <= STOP;
            r_tx_cnt   <= {CNT_W{1'b0}};
            r_tx       <= 1'b1;
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= {CNT_W{1'b0}};
            if (w_tx_accept) begin
              r_tx_shift <= i_tx_data;
`ifdef UART_PARITY_EN
              r_tx_par   <= parity_even(32'(i_tx_data));
`endif
              r_tx       <= 1'b0;
              r_tx_ready <= 1'b0;
              r_tx_state <= START;
            end else begin
              r_tx       <= 1'b1;
              r_tx_ready <= 1'b1;
              r_tx_state <= IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
            if (r_tx_cnt == CNT_W'(CLKS_PER_BIT - 2)) begin
              r_tx_ready <= 1'b1;
            end else begin
              r_tx_ready <= 1'b0;
            end
          end
        end
        default: begin
          r_tx_state <= IDLE;
          r_tx       <= 1'b1;
          r_tx_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx       = r_tx;
  assign o_tx_ready = r_tx_ready;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS)
  ) u_rx_core (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rx           (i_rx),
    .o_rx_data      (o_rx_data),
    .o_rx_valid     (o_rx_valid),
    .o_rx_frame_err (o_rx_frame_err)
  );

endmodule

// File: tb/tb_uart_master.sv
// -----------------------------------------------------------------------------
// tb_uart_master
// Directed self-checking bench for uart_master (CLKS_PER_BIT=16, 8 data bits,
// default build without UART_PARITY_EN).
// -----------------------------------------------------------------------------
module tb_uart_master;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       o_tx_ready;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_rx_frame_err;
  logic       o_tx;
  logic       rx_drv;
  logic       loop_en;
  wire        rx_line = loop_en ? o_tx : rx_drv;

  int n_chk;
  int n_err;
  int cyc;
  int n_ferr;
  int wide_pulse;
  logic prev_v;
  logic [7:0] rx_q[$];
  int         rx_t[$];

  uart_master #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_tx_data      (tx_data),
    .i_tx_valid     (tx_valid),
    .o_tx_ready     (o_tx_ready),
    .o_rx_data      (o_rx_data),
    .o_rx_valid     (o_rx_valid),
    .o_rx_frame_err (o_rx_frame_err),
    .o_tx           (o_tx),
    .i_rx           (rx_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every rx_valid pulse (data + cycle) and every frame error pulse.
  always @(negedge clk) begin
    if (o_rx_valid) begin
      rx_q.push_back(o_rx_data);
      rx_t.push_back(cyc);
      if (prev_v) wide_pulse++;
    end
    if (o_rx_frame_err) n_ferr++;
    prev_v = o_rx_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for tx_ready at a falling edge, then let one rising edge take the byte.
  task automatic tx_handshake(input logic [7:0] b, input string tag);
    int guard;
    tx_data  = b;
    tx_valid = 1'b1;
    guard    = 0;
    while (!o_tx_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_accept"}, 32'(o_tx_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Send one byte and check all ten line bits at mid-bit; seq holds them first-bit-leftmost.
  task automatic tx_frame(input logic [7:0] b, input logic [9:0] seq, input string tag);
    int rdy_hi;
    tx_handshake(b, tag);
    tx_valid = 1'b0;
    rdy_hi   = 0;
    for (int c = 0; c <= 160; c++) begin
      if (c > 0) @(negedge clk);
      if (c % 16 == 8) check_eq($sformatf("%s_bit%0d", tag, c / 16), 32'(o_tx), 32'(seq[9 - c / 16]));
      if (c < 159 && o_tx_ready) rdy_hi++;
    end
    check_eq({tag, "_ready_busy"}, 32'(rdy_hi), 32'd0);
    check_eq({tag, "_ready_end"}, 32'(o_tx_ready), 32'd1);
    check_eq({tag, "_tx_idle"}, 32'(o_tx), 32'd1);
  endtask

  // Drive one serial frame on rx (called at a falling edge), then 32 idle cycles.
  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (16) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (32) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int ferr0;
    int t0;
    int tx_low;
    logic [7:0] lb [3];
    n_chk = 0; n_err = 0; cyc = 0; n_ferr = 0; wide_pulse = 0; prev_v = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(o_tx), 32'd1);
    check_eq("rst_ready", 32'(o_tx_ready), 32'd1);
    check_eq("rst_rx_valid", 32'(o_rx_valid), 32'd0);
    check_eq("rst_frame_err", 32'(o_rx_frame_err), 32'd0);
    check_eq("rst_rx_data", 32'(o_rx_data), 32'h00);
    rst_n = 1'b1;
    tx_low = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!o_tx) tx_low++;
    end
    check_eq("idle_tx_high", 32'(tx_low), 32'd0);

    // TX 0xA5: 0 | 1 0 1 0 0 1 0 1 | 1
    tx_frame(8'hA5, 10'b0101001011, "txA5");

    // RX good frame 0x3C
    t0 = cyc;
    base = rx_q.size();
    ferr0 = n_ferr;
    rx_frame(8'h3C, 1'b1);
    check_eq("rx3C_count", 32'(rx_q.size() - base), 32'd1);
    check_eq("rx3C_data", 32'(o_rx_data), 32'h3C);
    check_eq("rx3C_ferr", 32'(n_ferr - ferr0), 32'd0);
    check_eq("rx3C_width", 32'(wide_pulse), 32'd0);
    if (rx_q.size() > base)
      check_eq("rx3C_latency", 32'((rx_t[base] - t0) >= 150 && (rx_t[base] - t0) <= 160), 32'd1);
    else
      check_eq("rx3C_latency", 32'd0, 32'd1);

    // RX 0x55 with stop bit 0, then good 0x81
    base = rx_q.size();
    ferr0 = n_ferr;
    rx_frame(8'h55, 1'b0);
    check_eq("rx55_ferr", 32'(n_ferr - ferr0), 32'd1);
    check_eq("rx55_novalid", 32'(rx_q.size() - base), 32'd0);
    check_eq("rx55_data_kept", 32'(o_rx_data), 32'h3C);
    rx_frame(8'h81, 1'b1);
    check_eq("rx81_count", 32'(rx_q.size() - base), 32'd1);
    check_eq("rx81_data", 32'(o_rx_data), 32'h81);

    // 4-cycle low glitch
    base = rx_q.size();
    ferr0 = n_ferr;
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("glitch_novalid", 32'(rx_q.size() - base), 32'd0);
    check_eq("glitch_noferr", 32'(n_ferr - ferr0), 32'd0);

    // Loopback, tx_valid held high across three bytes
    loop_en = 1'b1;
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A;
    base = rx_q.size();
    ferr0 = n_ferr;
    for (int i = 0; i < 3; i++) tx_handshake(lb[i], $sformatf("lb%0d", i));
    tx_valid = 1'b0;
    repeat (500) @(negedge clk);
    check_eq("lb_count", 32'(rx_q.size() - base), 32'd3);
    check_eq("lb_ferr", 32'(n_ferr - ferr0), 32'd0);
    if (rx_q.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) check_eq($sformatf("lb_data%0d", i), 32'(rx_q[base + i]), 32'(lb[i]));
      check_eq("lb_gap01", 32'(rx_t[base + 1] - rx_t[base]), 32'd160);
      check_eq("lb_gap12", 32'(rx_t[base + 2] - rx_t[base + 1]), 32'd160);
    end
    loop_en = 1'b0;
    repeat (20) @(negedge clk);

    // Reset in the middle of data bit 3 of 0xA5 (bit 3 = 0)
    tx_handshake(8'hA5, "rstmid");
    tx_valid = 1'b0;
    repeat (72) @(negedge clk);
    check_eq("rstmid_bit3", 32'(o_tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_tx", 32'(o_tx), 32'd1);
    check_eq("rstmid_ready", 32'(o_tx_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // 0x3C: 0 | 0 0 1 1 1 1 0 0 | 1
    tx_frame(8'h3C, 10'b0001111001, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
